// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_pkg
//  Description : Shared types and constants for the WS2812 serial output stage
//                (FSM states, default bit timing, pixel/GRB field layout).
//  Revision    : 1.0 - initial release
// ============================================================================
package ws2812_pkg;

    // Default bit timing at 100 MHz
    localparam int unsigned DEF_MAX_LEDS = 2048;
    localparam int unsigned DEF_T_BIT    = 125;
    localparam int unsigned DEF_T0H      = 40;
    localparam int unsigned DEF_T1H      = 80;
    localparam int unsigned DEF_T_RESET  = 8000;

    // Field widths
    localparam int unsigned ADDR_W  = 11;
    localparam int unsigned PIX_W   = 24;
    localparam int unsigned DEPTH_W = 20;
    localparam int unsigned BIT_W   = 5;

    // GRB field offsets inside a 24-bit pixel word (sent MSB first)
    localparam int unsigned GRB_G_OFS = 16;
    localparam int unsigned GRB_R_OFS = 8;
    localparam int unsigned GRB_B_OFS = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ws2812_if.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_if
//  Description : Pixel-write bus from the WS2812 controller plus the serial
//                line and status returned by the output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ws2812_if;
    import ws2812_pkg::*;

    logic               write;
    logic [ADDR_W-1:0]  address;
    logic [PIX_W-1:0]   rgb_data;
    logic [DEPTH_W-1:0] data_depth;
    logic               dout;
    logic               busy;
    logic               frame_done;

    modport master (
        output write, address, rgb_data, data_depth,
        input  dout, busy, frame_done
    );

    modport slave (
        input  write, address, rgb_data, data_depth,
        output dout, busy, frame_done
    );

endinterface
`default_nettype wire

// File: rtl/ws2812_pixel_ram.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_pixel_ram
//  Description : Simple dual-port frame buffer, MAX_LEDS x 24 bits. One
//                synchronous write port, one synchronous read port with a
//                single cycle of read latency (block-RAM friendly, no reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_pixel_ram
    import ws2812_pkg::*;
#(
    parameter int unsigned MAX_LEDS = DEF_MAX_LEDS
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [PIX_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [PIX_W-1:0]  rdata
);

    localparam int unsigned IDX_W = (MAX_LEDS > 1) ? $clog2(MAX_LEDS) : 1;

    logic [PIX_W-1:0] r_mem [MAX_LEDS];

    // Write port and registered read port share the system clock
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr[IDX_W-1:0]] <= wdata;
        end
        rdata <= r_mem[raddr[IDX_W-1:0]];
    end

endmodule
`default_nettype wire

// File: rtl/ws2812_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_tx
//  Description : Captures pixel writes into a frame buffer and, whenever the
//                buffer changed, streams the first data_depth pixels onto the
//                WS2812 single-wire line followed by the latch gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_tx
    import ws2812_pkg::*;
#(
    parameter int unsigned MAX_LEDS = DEF_MAX_LEDS,
    parameter int unsigned T_BIT    = DEF_T_BIT,
    parameter int unsigned T0H      = DEF_T0H,
    parameter int unsigned T1H      = DEF_T1H,
    parameter int unsigned T_RESET  = DEF_T_RESET
) (
    input  logic    clk,
    input  logic    rst_n,
    ws2812_if.slave bus
);

    localparam int unsigned CYC_W  = $clog2(max_u(max_u(T_BIT, T_RESET), 2));
    localparam int unsigned NPIX_W = $clog2(MAX_LEDS + 1);

    localparam logic [CYC_W-1:0]   C_T0H_M1    = CYC_W'(T0H - 1);
    localparam logic [CYC_W-1:0]   C_T1H_M1    = CYC_W'(T1H - 1);
    localparam logic [CYC_W-1:0]   C_TBIT_M1   = CYC_W'(T_BIT - 1);
    localparam logic [CYC_W-1:0]   C_TRST_M1   = CYC_W'(T_RESET - 1);
    localparam logic [CYC_W-1:0]   C_CYC_ONE   = CYC_W'(1);
    localparam logic [BIT_W-1:0]   C_BIT_MSB   = BIT_W'(PIX_W - 1);
    localparam logic [DEPTH_W-1:0] C_DEPTH_MAX = DEPTH_W'(MAX_LEDS);
    localparam logic [NPIX_W-1:0]  C_NPIX_MAX  = NPIX_W'(MAX_LEDS);

    state_t             r_state, w_state_nxt;
    logic [CYC_W-1:0]   r_cyc, w_cyc_nxt;
    logic [BIT_W-1:0]   r_bit, w_bit_nxt;
    logic [ADDR_W-1:0]  r_idx, w_idx_nxt;
    logic [NPIX_W-1:0]  r_npix, w_npix_nxt;
    logic [PIX_W-1:0]   r_shift, w_shift_nxt;
    logic [PIX_W-1:0]   r_hold, w_hold_nxt;
    logic               r_dirty, w_dirty_nxt;
    logic               r_dout, r_busy, r_frame_done;

    logic               w_wr_en;
    logic               w_last_pix;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [PIX_W-1:0]   w_rd_data;

    assign w_wr_en    = bus.write && (32'(bus.address) < MAX_LEDS);
    assign w_last_pix = (32'(r_idx) + 32'd1) == 32'(r_npix);
    // While idle the read port sits on pixel 0, so its word is ready in FETCH;
    // afterwards it points at the next pixel for the prefetch.
    assign w_rd_addr  = (r_state == ST_IDLE) ? '0 : r_idx + 11'd1;

    ws2812_pixel_ram #(
        .MAX_LEDS (MAX_LEDS)
    ) u_ram (
        .clk   (clk),
        .we    (w_wr_en),
        .waddr (bus.address),
        .wdata (bus.rgb_data),
        .raddr (w_rd_addr),
        .rdata (w_rd_data)
    );

    // State register plus all datapath registers and the registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cyc        <= '0;
            r_bit        <= '0;
            r_idx        <= '0;
            r_npix       <= '0;
            r_shift      <= '0;
            r_hold       <= '0;
            r_dirty      <= 1'b0;
            r_dout       <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cyc        <= w_cyc_nxt;
            r_bit        <= w_bit_nxt;
            r_idx        <= w_idx_nxt;
            r_npix       <= w_npix_nxt;
            r_shift      <= w_shift_nxt;
            r_hold       <= w_hold_nxt;
            r_dirty      <= w_dirty_nxt;
            r_dout       <= (r_state == ST_HIGH);
            r_busy       <= (r_state == ST_HIGH) || (r_state == ST_LOW) || (r_state == ST_GAP);
            r_frame_done <= (r_state == ST_GAP) && (r_cyc == C_TRST_M1);
        end
    end

    // Next-state logic: frame start, per-bit high/low phases, latch gap
    always_comb begin
        w_state_nxt = r_state;
        w_cyc_nxt   = r_cyc;
        w_bit_nxt   = r_bit;
        w_idx_nxt   = r_idx;
        w_npix_nxt  = r_npix;
        w_shift_nxt = r_shift;
        w_hold_nxt  = r_hold;
        w_dirty_nxt = r_dirty;

        case (r_state)
            ST_IDLE: begin
                if (r_dirty) begin
                    w_dirty_nxt = 1'b0;
                    w_cyc_nxt   = '0;
                    w_npix_nxt  = (bus.data_depth > C_DEPTH_MAX) ? C_NPIX_MAX
                                                                 : bus.data_depth[NPIX_W-1:0];
                    w_state_nxt = (w_npix_nxt == '0) ? ST_GAP : ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_shift_nxt = w_rd_data;
                w_idx_nxt   = '0;
                w_bit_nxt   = C_BIT_MSB;
                w_cyc_nxt   = '0;
                w_state_nxt = ST_HIGH;
            end
            ST_HIGH: begin
                w_cyc_nxt = r_cyc + 1'b1;
                // Next pixel's word lands one cycle after the pixel starts
                if ((r_bit == C_BIT_MSB) && (r_cyc == C_CYC_ONE)) begin
                    w_hold_nxt = w_rd_data;
                end
                if (r_cyc == (r_shift[PIX_W-1] ? C_T1H_M1 : C_T0H_M1)) begin
                    w_state_nxt = ST_LOW;
                end
            end
            ST_LOW: begin
                if (r_cyc == C_TBIT_M1) begin
                    w_cyc_nxt = '0;
                    if (r_bit == '0) begin
                        if (w_last_pix) begin
                            w_state_nxt = ST_GAP;
                        end else begin
                            w_idx_nxt   = r_idx + 11'd1;
                            w_shift_nxt = r_hold;
                            w_bit_nxt   = C_BIT_MSB;
                            w_state_nxt = ST_HIGH;
                        end
                    end else begin
                        w_bit_nxt   = r_bit - 1'b1;
                        w_shift_nxt = {r_shift[PIX_W-2:0], 1'b0};
                        w_state_nxt = ST_HIGH;
                    end
                end else begin
                    w_cyc_nxt = r_cyc + 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cyc == C_TRST_M1) begin
                    w_cyc_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cyc_nxt = r_cyc + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A write landing in the same cycle the flag is consumed re-arms it
        if (w_wr_en) begin
            w_dirty_nxt = 1'b1;
        end
    end

    assign bus.dout       = r_dout;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws2812_tx
//  Description : Directed self-checking bench for ws2812_tx. A line monitor
//                decodes dout high times into bits and measures bit periods,
//                busy length and frame_done timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_tx;
    import ws2812_pkg::*;

    localparam int unsigned MAXL = 4;
    localparam int unsigned TB   = 125;
    localparam int unsigned T0   = 40;
    localparam int unsigned T1   = 80;
    localparam int unsigned TR   = 400;
    localparam int          PXC  = 24 * TB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    ws2812_if bus();

    ws2812_tx #(
        .MAX_LEDS (MAXL),
        .T_BIT    (TB),
        .T0H      (T0),
        .T1H      (T1),
        .T_RESET  (TR)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // Monitor state (written only by the monitor process)
    int bits[$];
    int n_rise, bad_hi, bad_per, fd_cnt, fd_hi, fd_time;
    int first_rise, last_rise, busy_rise, busy_len;
    bit in_frame;
    logic prev_dout = 1'b0, prev_fd = 1'b0, prev_busy = 1'b0;
    int clr_seen = 0;

    // Stimulus state
    int clr_seq = 0;
    int w_edge;

    // Line monitor: decode bits, check periods, time busy and frame_done
    always @(negedge clk) begin
        if (clr_seq != clr_seen) begin
            clr_seen   = clr_seq;
            bits.delete();
            n_rise     = 0; bad_hi  = 0; bad_per  = 0;
            fd_cnt     = 0; fd_hi   = 0; fd_time  = 0;
            first_rise = 0; busy_len = 0; busy_rise = 0;
            in_frame   = 1'b0;
        end
        if (bus.dout && !prev_dout) begin
            if (in_frame && (cyc - last_rise != TB)) bad_per++;
            if (n_rise == 0) first_rise = cyc;
            last_rise = cyc;
            n_rise++;
            in_frame = 1'b1;
        end
        if (!bus.dout && prev_dout) begin
            if (cyc - last_rise == T1)      bits.push_back(1);
            else if (cyc - last_rise == T0) bits.push_back(0);
            else                            bad_hi++;
        end
        if (bus.frame_done) begin
            fd_hi++;
            if (!prev_fd) begin
                fd_cnt++;
                fd_time  = cyc;
                in_frame = 1'b0;
            end
        end
        if (bus.busy && !prev_busy) busy_rise = cyc;
        if (!bus.busy && prev_busy) busy_len = cyc - busy_rise;
        prev_dout = bus.dout;
        prev_fd   = bus.frame_done;
        prev_busy = bus.busy;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mon_clear();
        clr_seq++;
        tick();
    endtask

    task automatic wr(input logic [10:0] a, input logic [23:0] d);
        bus.write    = 1'b1;
        bus.address  = a;
        bus.rgb_data = d;
        w_edge       = cyc + 1;
        tick();
        bus.write    = 1'b0;
    endtask

    task automatic wait_fd(input int n, input int budget);
        int k = 0;
        while (fd_cnt < n && k < budget) begin
            tick();
            k++;
        end
        if (fd_cnt < n) check("timeout_frame_done", fd_cnt, n);
    endtask

    function automatic logic [23:0] pix(input int k);
        logic [23:0] v = '0;
        if (bits.size() < 24 * (k + 1)) return 24'hxxxxxx;
        for (int i = 0; i < 24; i++) v = {v[22:0], (bits[24 * k + i] != 0)};
        return v;
    endfunction

    initial begin
        int w0;
        int k;
        bus.write      = 1'b0;
        bus.address    = '0;
        bus.rgb_data   = '0;
        bus.data_depth = '0;

        // Reset state
        repeat (3) tick();
        check("rst_dout", bus.dout, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_frame_done", bus.frame_done, 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // Single pixel A50F00
        bus.data_depth = 20'd1;
        mon_clear();
        wr(11'd0, 24'hA50F00);
        w0 = w_edge;
        wait_fd(1, PXC + TR + 100);
        repeat (50) tick();
        check("single_pix", pix(0), 24'hA50F00);
        check("single_nbits", bits.size(), 24);
        check("single_bad_high", bad_hi, 0);
        check("single_bad_period", bad_per, 0);
        check("single_latency", first_rise - w0, 3);
        check("single_busy_len", busy_len, PXC + TR);
        check("single_frame_len", fd_time - w0, 2 + PXC + TR);
        check("single_fd_count", fd_cnt, 1);
        check("single_fd_width", fd_hi, 1);
        check("single_busy_end", bus.busy, 0);

        // Multi-pixel continuity; trailing writes re-arm one more frame
        bus.data_depth = 20'd3;
        mon_clear();
        wr(11'd0, 24'hFFFFFF);
        wr(11'd1, 24'h000000);
        wr(11'd2, 24'h800001);
        wait_fd(2, 2 * (3 * PXC + TR) + 200);
        repeat (10) tick();
        check("multi_nbits", bits.size(), 144);
        check("multi_p0", pix(0), 24'hFFFFFF);
        check("multi_p1", pix(1), 24'h000000);
        check("multi_p2", pix(2), 24'h800001);
        check("multi_f2_p2", pix(5), 24'h800001);
        check("multi_bad_period", bad_per, 0);
        check("multi_bad_high", bad_hi, 0);
        check("multi_busy_len", busy_len, 3 * PXC + TR);
        check("multi_fd_count", fd_cnt, 2);

        // Write pixel 1 while pixel 0 is on the line
        bus.data_depth = 20'd2;
        mon_clear();
        wr(11'd0, 24'h123456);
        repeat (1000) tick();
        wr(11'd1, 24'h0F0F0F);
        wait_fd(2, 2 * (2 * PXC + TR) + 200);
        repeat (10) tick();
        check("wdur_f1_p0", pix(0), 24'h123456);
        check("wdur_f1_p1_old", pix(1), 24'h000000);
        check("wdur_f2_p0", pix(2), 24'h123456);
        check("wdur_f2_p1_new", pix(3), 24'h0F0F0F);
        check("wdur_fd_count", fd_cnt, 2);

        // Clamp: data_depth all ones -> MAX_LEDS pixels
        bus.data_depth = 20'hFFFFF;
        mon_clear();
        wr(11'd3, 24'h00FF00);
        wait_fd(1, 4 * PXC + TR + 200);
        repeat (10) tick();
        check("clamp_nbits", bits.size(), 96);
        check("clamp_p2", pix(2), 24'h800001);
        check("clamp_p3", pix(3), 24'h00FF00);
        check("clamp_busy_len", busy_len, 4 * PXC + TR);
        check("clamp_fd_count", fd_cnt, 1);

        // Out-of-range address is ignored and starts nothing
        mon_clear();
        wr(11'd5, 24'hFFFFFF);
        repeat (50) tick();
        check("oor_busy", bus.busy, 0);
        check("oor_rises", n_rise, 0);

        // Zero length: only the latch gap
        bus.data_depth = 20'd0;
        mon_clear();
        wr(11'd0, 24'hAAAAAA);
        w0 = w_edge;
        wait_fd(1, TR + 100);
        repeat (10) tick();
        check("zero_rises", n_rise, 0);
        check("zero_busy_len", busy_len, TR);
        check("zero_frame_len", fd_time - w0, 1 + TR);
        check("zero_fd_count", fd_cnt, 1);

        // Reset during a high phase
        bus.data_depth = 20'd1;
        mon_clear();
        wr(11'd0, 24'hFFFFFF);
        k = 0;
        while (!bus.dout && k < 100) begin
            tick();
            k++;
        end
        check("rstmid_dout_seen", bus.dout, 1);
        repeat (10) tick();
        rst_n = 1'b0;
        #1;
        check("rstmid_dout_async", bus.dout, 0);
        check("rstmid_busy", bus.busy, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        mon_clear();
        repeat (PXC + 100) tick();
        check("rstmid_no_rise", n_rise, 0);
        check("rstmid_busy_after", bus.busy, 0);
        check("rstmid_no_fd", fd_cnt, 0);

        // Write landing in the IDLE-exit cycle
        bus.data_depth = 20'd1;
        mon_clear();
        wr(11'd0, 24'hC3C3C3);
        wr(11'd1, 24'h111111);
        wait_fd(2, 2 * (PXC + TR) + 200);
        repeat (PXC + TR + 100) tick();
        check("coll_fd_count", fd_cnt, 2);
        check("coll_nbits", bits.size(), 48);
        check("coll_f1", pix(0), 24'hC3C3C3);
        check("coll_f2", pix(1), 24'hC3C3C3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
